// File: rtl/ch4_pkg.sv
// Shared constants and types for the channel 4 noise generator.
// Divider base table, LFSR seed, full-length value and the NR42 envelope layout.
package ch4_pkg;

  // Base divisor for nr43[2:0]; index 0 is the rightmost entry.
  localparam logic [7:0][4:0] DIV_TAB = {5'd28, 5'd24, 5'd20, 5'd16,
                                         5'd12, 5'd8,  5'd4,  5'd2};

  localparam logic [14:0] LFSR_SEED = 15'h7FFF;
  localparam int          LEN_MAX   = 64;

  // Field order mirrors the NR42 register, so a plain cast unpacks it.
  typedef struct packed {
    logic [3:0] vol;
    logic       dir;
    logic [2:0] period;
  } env_t;

endpackage

// File: rtl/ch4_envelope.sv
// Channel 4 volume envelope: vol register and period counter, stepped by tick_env.
// One clk from trigger/tick to new vol; no backpressure, pulses are always accepted.
module ch4_envelope
  import ch4_pkg::*;
(
  input  logic       clk,
  input  logic       apu_reset,
  input  logic       trigger,
  input  logic       tick_env,
  input  logic [7:0] nr42,
  output logic [3:0] vol
);

  env_t       cfg;
  logic [2:0] env_cnt;
  logic       halted;

  assign cfg = env_t'(nr42);

  always_ff @(posedge clk) begin
    if (apu_reset) begin
      vol     <= 4'd0;
      env_cnt <= 3'd0;
      halted  <= 1'b0;
    end else if (trigger) begin
      vol     <= cfg.vol;
      env_cnt <= cfg.period;
      halted  <= 1'b0;
    end else if (tick_env && (cfg.period != 3'd0) && !halted) begin
      // A count of 0 here means the period was changed from 0; treat it as due.
      if (env_cnt <= 3'd1) begin
        env_cnt <= cfg.period;
        if (cfg.dir) begin
          if (vol == 4'hF) halted <= 1'b1;
          else             vol    <= vol + 4'd1;
        end else begin
          if (vol == 4'h0) halted <= 1'b1;
          else             vol    <= vol - 4'd1;
        end
      end else begin
        env_cnt <= env_cnt - 3'd1;
      end
    end
  end

endmodule

// File: rtl/ch4_noise_gen.sv
// Channel 4 noise generator: divider, LFSR, length counter and registered 4-bit sample (1 clk latency).
// No backpressure; optional CH4_LFSR_OBS_EN adds the lfsr_q debug readback port.
module ch4_noise_gen
  import ch4_pkg::*;
#(
  parameter int DIV_W = 20,
  parameter int LEN_W = 6
)(
  input  logic             clk,
  input  logic             apu_reset,
  input  logic             tick_1m,
  input  logic             tick_len,
  input  logic             tick_env,
  input  logic             len_load,
  input  logic [LEN_W-1:0] len_data,
  input  logic [7:0]       nr42,
  input  logic [7:0]       nr43,
  input  logic             len_en,
  input  logic             trigger,
  output logic [3:0]       ch4_out,
  output logic             ch4_active,
  output logic             dac_en
`ifdef CH4_LFSR_OBS_EN
  ,
  output logic [14:0]      lfsr_q
`endif
);

  // One extra bit so a full length of 64 is distinct from an expired counter.
  localparam int CNT_W = LEN_W + 1;

  logic [DIV_W-1:0] divider;
  logic [DIV_W-1:0] period;
  logic [14:0]      lfsr;
  logic [14:0]      lfsr_step;
  logic             lfsr_fb;
  logic             lfsr_hold;
  logic             div_expire;
  logic [CNT_W-1:0] length;
  logic [CNT_W-1:0] length_ld;
  logic [CNT_W-1:0] length_cur;
  logic [3:0]       vol;

  assign dac_en     = |nr42[7:3];
  assign period     = DIV_W'(DIV_TAB[nr43[2:0]]) << nr43[7:4];
  assign lfsr_hold  = nr43[7:4] >= 4'd14;
  assign div_expire = divider <= DIV_W'(1);
  assign length_ld  = CNT_W'(LEN_MAX) - CNT_W'(len_data);
  assign length_cur = len_load ? length_ld : length;
  assign lfsr_fb    = lfsr[0] ^ lfsr[1];

  always_comb begin
    lfsr_step = {lfsr_fb, lfsr[14:1]};
    if (nr43[3]) lfsr_step[6] = lfsr_fb;
  end

  always_ff @(posedge clk) begin
    if (apu_reset) begin
      divider    <= '0;
      lfsr       <= LFSR_SEED;
      length     <= '0;
      ch4_active <= 1'b0;
      ch4_out    <= 4'd0;
    end else begin
      ch4_out <= (ch4_active && !lfsr[0]) ? vol : 4'd0;
      if (trigger) begin
        divider    <= period;
        lfsr       <= LFSR_SEED;
        length     <= (length_cur == '0) ? CNT_W'(LEN_MAX) : length_cur;
        ch4_active <= dac_en;
      end else begin
        if (!dac_en) ch4_active <= 1'b0;

        if (len_load) begin
          length <= length_ld;
        end else if (tick_len && len_en && (length != '0)) begin
          length <= length - CNT_W'(1);
          if (length == CNT_W'(1)) ch4_active <= 1'b0;
        end

        if (tick_1m) begin
          if (div_expire) begin
            divider <= period;
            if (!lfsr_hold) lfsr <= lfsr_step;
          end else begin
            divider <= divider - DIV_W'(1);
          end
        end
      end
    end
  end

  ch4_envelope u_env (
    .clk       (clk),
    .apu_reset (apu_reset),
    .trigger   (trigger),
    .tick_env  (tick_env),
    .nr42      (nr42),
    .vol       (vol)
  );

`ifdef CH4_LFSR_OBS_EN
  assign lfsr_q = lfsr;
`endif

endmodule

// File: tb/tb_ch4_noise_gen.sv
// Scoreboard bench for ch4_noise_gen: directed scenarios then random pulses,
// expected outputs come from an integer reference model, checked every cycle.
module tb_ch4_noise_gen;

  logic       clk = 1'b0;
  logic       apu_reset, tick_1m, tick_len, tick_env, len_load, len_en, trigger;
  logic [5:0] len_data;
  logic [7:0] nr42, nr43;
  logic [3:0] ch4_out;
  logic       ch4_active, dac_en;
`ifdef CH4_LFSR_OBS_EN
  logic [14:0] lfsr_q;
`endif

  always #5 clk = ~clk;

  ch4_noise_gen dut (
    .clk        (clk),
    .apu_reset  (apu_reset),
    .tick_1m    (tick_1m),
    .tick_len   (tick_len),
    .tick_env   (tick_env),
    .len_load   (len_load),
    .len_data   (len_data),
    .nr42       (nr42),
    .nr43       (nr43),
    .len_en     (len_en),
    .trigger    (trigger),
    .ch4_out    (ch4_out),
    .ch4_active (ch4_active),
    .dac_en     (dac_en)
`ifdef CH4_LFSR_OBS_EN
    ,
    .lfsr_q     (lfsr_q)
`endif
  );

  typedef struct {
    int out;
    int active;
    int dac;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  // Reference model state, plain integers.
  int m_lfsr, m_div, m_len, m_active, m_out, m_vol, m_env, m_env_stop;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
  endtask

  function automatic int lfsr_clock(input int v, input bit narrow);
    int x;
    x = (v ^ (v >> 1)) & 1;
    v = (v >> 1) | (x << 14);
    if (narrow) v = (v & ~(1 << 6)) | (x << 6);
    return v;
  endfunction

  // Divisor table is 2 for code 0 and 4*r otherwise.
  function automatic int div_period(input int r, input int s);
    int base;
    base = (r == 0) ? 2 : 4 * r;
    return base * (1 << s);
  endfunction

  task automatic model_step();
    int   p, s, per, len_n, out_n, act_n, dac;
    exp_t e;
    dac = (nr42[7:3] != 5'd0) ? 1 : 0;
    if (apu_reset) begin
      m_lfsr = 'h7FFF; m_div = 0; m_len = 0; m_active = 0; m_out = 0;
      m_vol = 0; m_env = 0; m_env_stop = 0;
    end else begin
      out_n = (m_active != 0 && (m_lfsr % 2) == 0) ? m_vol : 0;
      s     = int'(nr43[7:4]);
      per   = div_period(int'(nr43[2:0]), s);
      p     = int'(nr42[2:0]);
      len_n = len_load ? 64 - int'(len_data) : m_len;
      act_n = (m_active != 0 && dac != 0) ? 1 : 0;
      if (trigger) begin
        if (len_n == 0) len_n = 64;
        act_n = dac; m_div = per; m_lfsr = 'h7FFF;
        m_vol = int'(nr42[7:4]); m_env = p; m_env_stop = 0;
      end else begin
        if (tick_len && len_en && !len_load && len_n > 0) begin
          len_n--;
          if (len_n == 0) act_n = 0;
        end
        if (tick_1m) begin
          m_div--;
          if (m_div <= 0) begin
            m_div = per;
            if (s < 14) m_lfsr = lfsr_clock(m_lfsr, nr43[3]);
          end
        end
        if (tick_env && p != 0 && m_env_stop == 0) begin
          m_env--;
          if (m_env <= 0) begin
            m_env = p;
            if (nr42[3]) begin
              if (m_vol == 15) m_env_stop = 1; else m_vol++;
            end else begin
              if (m_vol == 0) m_env_stop = 1; else m_vol--;
            end
          end
        end
      end
      m_len = len_n; m_active = act_n; m_out = out_n;
    end
    e.out = m_out; e.active = m_active; e.dac = dac;
    exp_q.push_back(e);
  endtask

  // Predict the coming edge, let it happen, then drop the one-clk pulses.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
      trigger = 0; len_load = 0; tick_1m = 0; tick_len = 0; tick_env = 0;
    end
  endtask

  task automatic ticks_1m(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1m = 1;
      cyc(1);
    end
  endtask

  // Monitor: compares every output cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ch4_out", int'(ch4_out), e.out);
        check("ch4_active", int'(ch4_active), e.active);
        check("dac_en", int'(dac_en), e.dac);
      end
    end
  end

  initial begin
    apu_reset = 1; tick_1m = 0; tick_len = 0; tick_env = 0; len_load = 0;
    len_en = 0; trigger = 0; len_data = 6'd0; nr42 = 8'hF0; nr43 = 8'h00;
    @(negedge clk);
    cyc(3);
    apu_reset = 0;
    cyc(2);

    // Noise with the 15-bit and 7-bit widths.
    trigger = 1; cyc(1);
    ticks_1m(40);
    nr43 = 8'h08; trigger = 1; cyc(1);
    ticks_1m(600);

    // Shift 14 after the LFSR has been running: it must freeze.
    nr43 = 8'h00; trigger = 1; cyc(1);
    ticks_1m(37);
    nr43 = 8'hE0;
    ticks_1m(60);
    nr43 = 8'hF1;
    ticks_1m(20);

    // Length 2 expires on the second tick; then full length 64.
    nr43 = 8'h01; len_en = 1;
    len_data = 6'd62; len_load = 1; cyc(1);
    trigger = 1; cyc(1);
    for (int i = 0; i < 3; i++) begin
      tick_len = 1; tick_1m = 1; cyc(1);
      ticks_1m(2);
    end
    len_data = 6'd0; len_load = 1; trigger = 1; cyc(1);
    for (int i = 0; i < 66; i++) begin
      tick_len = 1; cyc(1);
      ticks_1m(1);
    end

    // Envelope up to 15, then down to 0.
    len_en = 0; nr42 = 8'h19; trigger = 1; cyc(1);
    for (int i = 0; i < 20; i++) begin
      tick_env = 1; cyc(1);
      ticks_1m(2);
    end
    nr42 = 8'hF2; trigger = 1; cyc(1);
    for (int i = 0; i < 34; i++) begin
      tick_env = 1; cyc(1);
      ticks_1m(2);
    end

    // Trigger and tick_len together with length 1.
    nr42 = 8'hF0; len_en = 1; len_data = 6'd63; len_load = 1; cyc(1);
    trigger = 1; cyc(1);
    trigger = 1; tick_len = 1; cyc(1);
    ticks_1m(4);
    tick_len = 1; cyc(1);
    cyc(2);

    // DAC off kills the channel; trigger cannot restart it.
    len_en = 0; trigger = 1; cyc(1);
    ticks_1m(6);
    nr42 = 8'h00; cyc(2);
    trigger = 1; cyc(1);
    ticks_1m(4);

    // Reset in the middle of activity.
    nr42 = 8'hA7; trigger = 1; cyc(1);
    ticks_1m(10);
    apu_reset = 1; tick_1m = 1; cyc(1);
    apu_reset = 0; cyc(2);

    // Random pulses and register writes.
    for (int i = 0; i < 2500; i++) begin
      tick_1m  = ($urandom_range(0, 1) == 1);
      tick_len = ($urandom_range(0, 15) == 0);
      tick_env = ($urandom_range(0, 15) == 0);
      trigger  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 63) == 0) begin
        len_load = 1; len_data = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 99) == 0) begin
        nr42   = 8'($urandom_range(0, 255));
        len_en = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 79) == 0) begin
        nr43 = {4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
        if ($urandom_range(0, 7) == 0) nr43[7:4] = 4'd14;
      end
      apu_reset = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    apu_reset = 0;
    cyc(2);

    stim_done = 1;
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
